fab_warmboot_ctrl: RTL
======================

FAB_WARMBOOT_CTRL -- requirements
Module: fab_warmboot_ctrl

Interface
REQ-001 SHALL provide parameter NUM_SLOTS, default 4, number of valid bitstream slots (1..16).
REQ-002 SHALL provide parameter BOOT_PULSE_CYCLES, default 4, boot_o high time in cycles (1..255).
REQ-003 SHALL provide parameter HOLD_CYCLES, default 16, post-pulse hold in cycles (0..255).
REQ-004 SHALL provide parameter KEY, default 8'hA5, unlock key a request must carry.
REQ-005 SHALL have port clk_i  input  1  single clock for all logic.
REQ-006 SHALL have port rst_in  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid_i  input  1  warmboot request valid.
REQ-008 SHALL have port req_ready_o  output  1  controller can accept a request.
REQ-009 SHALL have port req_slot_i  input  4  requested slot.
REQ-010 SHALL have port req_key_i  input  8  unlock key.
REQ-011 SHALL have port slot_o  output  4  slot select to the warmboot primitive.
REQ-012 SHALL have port boot_o  output  1  boot strobe to the warmboot primitive.
REQ-013 SHALL have port busy_o  output  1  sequence in progress.
REQ-014 SHALL have port err_o  output  1  sticky rejected-request flag.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, PULSE, HOLD; all outputs registered.
REQ-016 SHALL assert req_ready_o only in IDLE; a request is accepted when req_valid_i and req_ready_o are both 1 at a rising clk_i edge.
REQ-017 SHALL treat an accepted request as valid iff req_key_i == KEY and req_slot_i < NUM_SLOTS.
REQ-018 On valid accept: SHALL latch req_slot_i into slot_o, clear err_o, enter SETUP.
REQ-019 On invalid accept: SHALL set err_o, stay in IDLE, leave slot_o and boot_o unchanged.
REQ-020 err_o SHALL remain set until the next valid accept or reset.
REQ-021 SETUP SHALL last exactly 2 cycles with boot_o=0 and slot_o stable (setup margin to the primitive), then enter PULSE.
REQ-022 PULSE SHALL hold boot_o=1 for exactly BOOT_PULSE_CYCLES cycles, then enter HOLD.
REQ-023 HOLD SHALL hold boot_o=0 and slot_o stable for HOLD_CYCLES cycles, then return to IDLE; HOLD_CYCLES=0 SHALL go PULSE->IDLE directly.
REQ-024 slot_o SHALL keep the last latched slot in IDLE after a sequence completes.
REQ-025 busy_o SHALL be 1 in SETUP, PULSE, HOLD and 0 in IDLE.
REQ-026 First boot_o=1 cycle SHALL be 3 rising edges after the accept edge (accept edge, 2 SETUP cycles).
REQ-027 req_valid_i while busy SHALL be ignored (not queued, err_o unaffected).
REQ-028 Internal cycle counter SHALL be 8 bits, load at state entry, count down, no wrap past zero.
REQ-029 Request inputs are sampled only at accept; changes after accept SHALL NOT affect the sequence.

Reset
REQ-030 On rst_in=0, asynchronously: state=IDLE, slot_o=0, boot_o=0, busy_o=0, err_o=0, counter=0; req_ready_o=0 while rst_in=0.
REQ-031 Reset asserted mid-PULSE SHALL drop boot_o to 0 immediately, without waiting for a clock edge.
REQ-032 After rst_in deasserts, req_ready_o SHALL be 1 from the first rising clk_i edge.

Verification
REQ-033 Valid request (slot=2, key=A5, defaults) -> slot_o=2 at next edge; boot_o=1 for exactly 4 cycles starting 3 edges after accept; busy_o=1 for 2+4+16=22 cycles; then req_ready_o=1.
REQ-034 Wrong key (key=5A, slot=1) -> err_o=1, busy_o=0, boot_o never rises, slot_o unchanged; a following valid request clears err_o.
REQ-035 Slot out of range (slot=4, NUM_SLOTS=4) -> err_o=1, no sequence; slot=3 -> accepted.
REQ-036 Second req_valid_i during PULSE (slot=1) -> ignored; slot_o stays 2, exactly one boot pulse.
REQ-037 rst_in=0 in the 2nd PULSE cycle -> boot_o=0 combinationally, all outputs at reset values; after release, a new request runs a full sequence.
REQ-038 HOLD_CYCLES=0, BOOT_PULSE_CYCLES=1 -> 1-cycle boot pulse, busy_o=1 for exactly 3 cycles.

Source files
------------

// File: rtl/fab_warmboot_ctrl.sv
// Warmboot sequencer: accepts a keyed slot request, then drives slot/boot strobes to the FPGA warmboot primitive.
// Latency: first boot_o high 2 cycles after the accept edge's SETUP phase (3rd edge counting accept); busy for 2+PULSE+HOLD cycles.
// Backpressure: req_ready_o is high only in IDLE; requests presented while busy are dropped, not queued.
//
// Ports:
//   clk_i, rst_in                 clock, asynchronous active-low reset
//   req_valid_i/req_ready_o       request handshake; req_slot_i/req_key_i sampled only at accept
//   slot_o, boot_o                slot select and boot strobe to the warmboot primitive
//   busy_o, err_o                 sequence in progress, sticky rejected-request flag
module fab_warmboot_ctrl #(
    parameter int         NUM_SLOTS         = 4,
    parameter int         BOOT_PULSE_CYCLES = 4,
    parameter int         HOLD_CYCLES       = 16,
    parameter logic [7:0] KEY               = 8'hA5
) (
    input  logic       clk_i,
    input  logic       rst_in,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [3:0] req_slot_i,
    input  logic [7:0] req_key_i,
    output logic [3:0] slot_o,
    output logic       boot_o,
    output logic       busy_o,
    output logic       err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Counters hold "cycles remaining minus one" so a state exits when the count reaches zero.
    localparam logic [7:0] SETUP_LOAD = 8'd1;
    localparam logic [7:0] PULSE_LOAD = 8'(BOOT_PULSE_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD  = (HOLD_CYCLES == 0) ? 8'd0 : 8'(HOLD_CYCLES - 1);
    localparam logic [4:0] SLOT_LIMIT = 5'(NUM_SLOTS);

    state_t     state;
    logic [7:0] cnt;
    logic       accept;
    logic       req_ok;

    // req_ready_o is only ever high in IDLE, so accept implies IDLE.
    assign accept = req_valid_i & req_ready_o;
    assign req_ok = (req_key_i == KEY) && ({1'b0, req_slot_i} < SLOT_LIMIT);

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            slot_o      <= 4'd0;
            boot_o      <= 1'b0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
            req_ready_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready_o <= 1'b1;
                    if (accept) begin
                        if (req_ok) begin
                            slot_o      <= req_slot_i;
                            err_o       <= 1'b0;
                            busy_o      <= 1'b1;
                            req_ready_o <= 1'b0;
                            cnt         <= SETUP_LOAD;
                            state       <= SETUP;
                        end else begin
                            // Rejected: flag it, leave slot/boot untouched and stay ready.
                            err_o <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == 8'd0) begin
                        boot_o <= 1'b1;
                        cnt    <= PULSE_LOAD;
                        state  <= PULSE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                PULSE: begin
                    if (cnt == 8'd0) begin
                        boot_o <= 1'b0;
                        if (HOLD_CYCLES == 0) begin
                            busy_o      <= 1'b0;
                            req_ready_o <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            cnt   <= HOLD_LOAD;
                            state <= HOLD;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 8'd0) begin
                        busy_o      <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
